// File: rtl/cache_region_map_pkg.sv
// Shared definitions for the region map: config word-select codes and
// attribute bit positions, used by the RTL, software headers and the dcache.
package cache_region_map_pkg;

    // Config word select, i_cfg_addr[1:0]
    localparam logic [1:0] CRM_BASE = 2'd0;
    localparam logic [1:0] CRM_MASK = 2'd1;
    localparam logic [1:0] CRM_ATTR = 2'd2;
    localparam logic [1:0] CRM_RSVD = 2'd3;

    // Attribute bit positions
    localparam int CRM_EN    = 0;
    localparam int CRM_CACHE = 1;

    // Region index width for a given region count (at least one bit)
    function automatic int crm_lgn(input int nregions);
        return (nregions > 1) ? $clog2(nregions) : 1;
    endfunction

endpackage

// File: rtl/cache_region_map_prienc.sv
// Lowest-index-wins priority encoder over the registered region match vector.
// Purely combinational; o_index is 0 when nothing matches.
module region_prienc #(
    parameter int N   = 4,
    parameter int LGN = 2
) (
    input  logic [N-1:0]   i_match,
    output logic           o_hit,
    output logic [LGN-1:0] o_index
);

    // Scan from the top down so the lowest set bit is written last and wins
    always_comb begin
        o_hit   = |i_match;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_index = LGN'(i);
            end
        end
    end

endmodule

// File: rtl/cache_region_map.sv
// Runtime-programmable address classifier: maps a bus address to the
// lowest-index enabled region whose masked base matches, plus its cachable
// attribute. Two-stage valid/ready lookup pipeline and a single-cycle-ack
// config port into a flop-based base/mask/attr table.
//
// Handshake: a lookup transfers when i_valid && o_ready; a result transfers
// when o_valid && i_ready. o_ready = !o_valid || i_ready; when it is low both
// stages hold and every output stays stable.
module cache_region_map
    import cache_region_map_pkg::*;
#(
    parameter int                        AW        = 32,
    parameter int                        NREGIONS  = 4,
    parameter logic [NREGIONS*AW-1:0]    INIT_ADDR = '0,
    parameter logic [NREGIONS*AW-1:0]    INIT_MASK = '0,
    parameter logic [NREGIONS*2-1:0]     INIT_ATTR = '0,
    localparam int                       LGN       = crm_lgn(NREGIONS)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    // Lookup request
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [AW-1:0]  i_addr,
    // Lookup result
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_hit,
    output logic [LGN-1:0] o_region,
    output logic           o_cachable,
    // Config port
    input  logic           i_cfg_stb,
    input  logic           i_cfg_we,
    input  logic [LGN+1:0] i_cfg_addr,
    input  logic [AW-1:0]  i_cfg_data,
    output logic           o_cfg_ack,
    output logic [AW-1:0]  o_cfg_data
);

    // Region table: every entry is compared each cycle, so it lives in flops
    logic [AW-1:0] r_base [NREGIONS];
    logic [AW-1:0] r_mask [NREGIONS];
    logic [1:0]    r_attr [NREGIONS];

    // Stage 1 registers
    logic                r_s1_valid;
    logic [NREGIONS-1:0] r_s1_match;
    logic [NREGIONS-1:0] r_s1_cache;

    logic                w_advance;
    logic [NREGIONS-1:0] w_match;
    logic [NREGIONS-1:0] w_cache;
    logic                w_s2_hit;
    logic [LGN-1:0]      w_s2_index;
    logic                w_s2_cache;
    logic [LGN-1:0]      w_cfg_region;
    logic [1:0]          w_cfg_word;
    logic [NREGIONS-1:0] w_cfg_sel;
    logic [AW-1:0]       w_cfg_rdata;

    assign w_advance    = !o_valid || i_ready;
    assign o_ready      = w_advance;
    assign w_cfg_region = i_cfg_addr[LGN+1:2];
    assign w_cfg_word   = i_cfg_addr[1:0];

    // Per-region match against the current (pre-write) table contents
    always_comb begin
        w_match = '0;
        w_cache = '0;
        for (int r = 0; r < NREGIONS; r++) begin
            w_match[r] = r_attr[r][CRM_EN]
                         && ((i_addr & r_mask[r]) == (r_base[r] & r_mask[r]));
            w_cache[r] = r_attr[r][CRM_CACHE];
        end
    end

    // Config decode and read mux; an unimplemented region selects nothing
    always_comb begin
        w_cfg_sel   = '0;
        w_cfg_rdata = '0;
        for (int r = 0; r < NREGIONS; r++) begin
            w_cfg_sel[r] = (w_cfg_region == LGN'(r));
            if (w_cfg_sel[r]) begin
                case (w_cfg_word)
                    CRM_BASE: w_cfg_rdata = r_base[r];
                    CRM_MASK: w_cfg_rdata = r_mask[r];
                    CRM_ATTR: w_cfg_rdata = {{(AW-2){1'b0}}, r_attr[r]};
                    default:  w_cfg_rdata = '0;
                endcase
            end
        end
    end

    // Table update: reset to INIT values, otherwise config writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NREGIONS; r++) begin
                r_base[r] <= INIT_ADDR[r*AW +: AW];
                r_mask[r] <= INIT_MASK[r*AW +: AW];
                r_attr[r] <= INIT_ATTR[r*2 +: 2];
            end
        end else if (i_cfg_stb && i_cfg_we) begin
            for (int r = 0; r < NREGIONS; r++) begin
                if (w_cfg_sel[r]) begin
                    case (w_cfg_word)
                        CRM_BASE: r_base[r] <= i_cfg_data;
                        CRM_MASK: r_mask[r] <= i_cfg_data;
                        CRM_ATTR: r_attr[r] <= i_cfg_data[1:0];
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Config response: ack one cycle after every strobe, read data from the
    // table as it was before any same-cycle write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cfg_ack  <= 1'b0;
            o_cfg_data <= '0;
        end else begin
            o_cfg_ack  <= i_cfg_stb;
            if (i_cfg_stb) begin
                o_cfg_data <= i_cfg_we ? '0 : w_cfg_rdata;
            end
        end
    end

    region_prienc #(
        .N   (NREGIONS),
        .LGN (LGN)
    ) u_prienc (
        .i_match (r_s1_match),
        .o_hit   (w_s2_hit),
        .o_index (w_s2_index)
    );

    // Cachable bit of the lowest-index matching region
    always_comb begin
        w_s2_cache = 1'b0;
        for (int i = NREGIONS - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_s2_cache = r_s1_cache[i];
            end
        end
    end

    // Two-stage lookup pipeline; both stages move together on advance
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
            r_s1_cache <= '0;
            o_valid    <= 1'b0;
            o_hit      <= 1'b0;
            o_region   <= '0;
            o_cachable <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= i_valid;
            r_s1_match <= i_valid ? w_match : '0;
            r_s1_cache <= w_cache;
            o_valid    <= r_s1_valid;
            o_hit      <= w_s2_hit;
            o_region   <= w_s2_index;
            o_cachable <= w_s2_cache;
        end
    end

endmodule
